// File: rtl/cfg_info_streamer.sv
// Exposes the derived core configuration as a constant word table, via a burst stream and a 1-cycle read port.
// Define CFG_INFO_CHECKSUM_EN to append a two's-complement checksum word (index 8) to the table.
package config_pkg;
    typedef struct packed {
        int unsigned XLEN;
        int unsigned PLEN;
        int unsigned NR_SB_ENTRIES;
        int unsigned NrCommitPorts;
        int unsigned NrIssuePorts;
        logic        RVA;
        logic        RVB;
        logic        RVC;
        logic        RVD;
        logic        RVF;
        logic        RVH;
        logic        RVS;
        logic        RVU;
        logic        RVV;
        logic        RVZCB;
        logic        RVZCMP;
        logic        RVZiCond;
        logic        RVZicntr;
        logic        RVZihpm;
        logic        XF16;
        logic        XF16ALT;
        logic        XF8;
        logic        XFVec;
        logic        CvxifEn;
        logic        FpPresent;
        logic        DebugEn;
        logic        MmuPresent;
        logic        SuperscalarEn;
        int unsigned ICACHE_LINE_WIDTH;
        int unsigned ICACHE_SET_ASSOC;
        int unsigned ICACHE_INDEX_WIDTH;
        int unsigned DCACHE_LINE_WIDTH;
        int unsigned DCACHE_SET_ASSOC;
        int unsigned DCACHE_INDEX_WIDTH;
        int unsigned AxiDataWidth;
        int unsigned AxiIdWidth;
        int unsigned AxiAddrWidth;
        int unsigned NrPMPEntries;
        int unsigned InstrTlbEntries;
        int unsigned DataTlbEntries;
        int unsigned FLen;
        logic [63:0] DmBaseAddress;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;
endpackage

module cfg_info_streamer #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_data_o,
    output logic [3:0]  out_idx_o,
    output logic        out_last_o,
    output logic        done_o,
    output logic        busy_o,
    input  logic        rd_req_i,
    input  logic [3:0]  rd_addr_i,
    output logic        rd_rsp_valid_o,
    output logic [31:0] rd_data_o,
    output logic        rd_err_o
);
`ifdef CFG_INFO_CHECKSUM_EN
    localparam int unsigned NUM_WORDS = 9;
`else
    localparam int unsigned NUM_WORDS = 8;
`endif
    localparam logic [3:0] LAST_IDX = 4'(NUM_WORDS - 1);

    // Padded to 16 entries so any 4-bit index is legal; unused slots read as zero.
    function automatic logic [15:0][31:0] build_table();
        logic [15:0][31:0] t;
`ifdef CFG_INFO_CHECKSUM_EN
        logic [31:0] sum;
`endif
        t    = '0;
        t[0] = {16'(CVA6Cfg.PLEN), 16'(CVA6Cfg.XLEN)};
        t[1] = {16'(CVA6Cfg.NR_SB_ENTRIES), 8'(CVA6Cfg.NrCommitPorts), 8'(CVA6Cfg.NrIssuePorts)};
        t[2] = {9'b0, CVA6Cfg.SuperscalarEn, CVA6Cfg.MmuPresent, CVA6Cfg.DebugEn,
                CVA6Cfg.FpPresent, CVA6Cfg.CvxifEn, CVA6Cfg.XFVec, CVA6Cfg.XF8,
                CVA6Cfg.XF16ALT, CVA6Cfg.XF16, CVA6Cfg.RVZihpm, CVA6Cfg.RVZicntr,
                CVA6Cfg.RVZiCond, CVA6Cfg.RVZCMP, CVA6Cfg.RVZCB, CVA6Cfg.RVV,
                CVA6Cfg.RVU, CVA6Cfg.RVS, CVA6Cfg.RVH, CVA6Cfg.RVF, CVA6Cfg.RVD,
                CVA6Cfg.RVC, CVA6Cfg.RVB, CVA6Cfg.RVA};
        t[3] = {16'(CVA6Cfg.ICACHE_LINE_WIDTH), 8'(CVA6Cfg.ICACHE_SET_ASSOC), 8'(CVA6Cfg.ICACHE_INDEX_WIDTH)};
        t[4] = {16'(CVA6Cfg.DCACHE_LINE_WIDTH), 8'(CVA6Cfg.DCACHE_SET_ASSOC), 8'(CVA6Cfg.DCACHE_INDEX_WIDTH)};
        t[5] = {16'(CVA6Cfg.AxiDataWidth), 8'(CVA6Cfg.AxiIdWidth), 8'(CVA6Cfg.AxiAddrWidth)};
        t[6] = {8'(CVA6Cfg.NrPMPEntries), 8'(CVA6Cfg.InstrTlbEntries),
                8'(CVA6Cfg.DataTlbEntries), 8'(CVA6Cfg.FLen)};
        t[7] = CVA6Cfg.DmBaseAddress[31:0];
`ifdef CFG_INFO_CHECKSUM_EN
        sum = '0;
        for (int i = 0; i < 8; i++) sum = sum + t[i];
        t[8] = ~sum + 32'd1;
`endif
        return t;
    endfunction

    localparam logic [15:0][31:0] TABLE = build_table();

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
    state_t state;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_idx_o   <= '0;
            out_last_o  <= 1'b0;
            done_o      <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i && !abort_i) begin
                        state       <= STREAM;
                        out_valid_o <= 1'b1;
                        out_idx_o   <= '0;
                        out_data_o  <= TABLE[0];
                        out_last_o  <= 1'b0;
                        busy_o      <= 1'b1;
                    end
                end
                STREAM: begin
                    // Abort wins over a handshake in the same cycle.
                    if (abort_i) begin
                        state       <= IDLE;
                        out_valid_o <= 1'b0;
                        out_data_o  <= '0;
                        out_idx_o   <= '0;
                        out_last_o  <= 1'b0;
                        busy_o      <= 1'b0;
                    end else if (out_ready_i) begin
                        if (out_last_o) begin
                            state       <= DONE;
                            out_valid_o <= 1'b0;
                            done_o      <= 1'b1;
                        end else begin
                            out_idx_o  <= out_idx_o + 4'd1;
                            out_data_o <= TABLE[out_idx_o + 4'd1];
                            out_last_o <= (out_idx_o + 4'd1) == LAST_IDX;
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    out_data_o <= '0;
                    out_idx_o  <= '0;
                    out_last_o <= 1'b0;
                    busy_o     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CFG_INFO_CHECKSUM_EN
    logic [31:0] cksum_acc;

    // Running sum of accepted words; returns to zero after a complete checksummed stream.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cksum_acc <= '0;
        end else if ((state == IDLE && start_i && !abort_i) || (state != IDLE && abort_i)) begin
            cksum_acc <= '0;
        end else if (state == STREAM && out_valid_o && out_ready_i) begin
            cksum_acc <= cksum_acc + out_data_o;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_rsp_valid_o <= 1'b0;
            rd_data_o      <= '0;
            rd_err_o       <= 1'b0;
        end else begin
            rd_rsp_valid_o <= rd_req_i;
            rd_data_o      <= rd_req_i ? TABLE[rd_addr_i] : 32'd0;
            rd_err_o       <= rd_req_i && (32'(rd_addr_i) >= NUM_WORDS);
        end
    end

endmodule

// File: tb/tb_cfg_info_streamer.sv
// Randomized and directed bench for cfg_info_streamer against a transaction-level table/stream model.
module tb_cfg_info_streamer;
`ifdef CFG_INFO_CHECKSUM_EN
    localparam int N = 9;
`else
    localparam int N = 8;
`endif

    function automatic config_pkg::cva6_cfg_t mk_cfg();
        config_pkg::cva6_cfg_t c;
        c = '0;
        c.XLEN = 64;             c.PLEN = 56;
        c.NR_SB_ENTRIES = 8;     c.NrCommitPorts = 258;  c.NrIssuePorts = 1;
        c.RVA = 1; c.RVC = 1; c.RVD = 1; c.RVF = 1; c.RVS = 1; c.RVU = 1;
        c.RVZicntr = 1; c.XF16 = 1; c.FpPresent = 1; c.DebugEn = 1; c.MmuPresent = 1;
        c.ICACHE_LINE_WIDTH = 128; c.ICACHE_SET_ASSOC = 4; c.ICACHE_INDEX_WIDTH = 12;
        c.DCACHE_LINE_WIDTH = 128; c.DCACHE_SET_ASSOC = 8; c.DCACHE_INDEX_WIDTH = 12;
        c.AxiDataWidth = 64;     c.AxiIdWidth = 4;       c.AxiAddrWidth = 64;
        c.NrPMPEntries = 8;      c.InstrTlbEntries = 16; c.DataTlbEntries = 16; c.FLen = 64;
        c.DmBaseAddress = 64'h0000_0001_0000_0800;
        return c;
    endfunction

    localparam config_pkg::cva6_cfg_t CFG = mk_cfg();

    logic clk = 1'b0;
    logic rst, start, abort, out_ready, rd_req;
    logic [3:0] rd_addr;
    logic out_valid, out_last, done, busy, rd_rsp_valid, rd_err;
    logic [31:0] out_data, rd_data;
    logic [3:0] out_idx;

    cfg_info_streamer #(.CVA6Cfg(CFG)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_idx_o(out_idx), .out_last_o(out_last), .done_o(done), .busy_o(busy),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_rsp_valid_o(rd_rsp_valid),
        .rd_data_o(rd_data), .rd_err_o(rd_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected table straight from the field layout rules.
    int unsigned tbl[16];
    task automatic build_model();
        logic f[23];
        int unsigned s;
        foreach (tbl[i]) tbl[i] = 0;
        tbl[0] = ((CFG.PLEN % 65536) << 16) | (CFG.XLEN % 65536);
        tbl[1] = ((CFG.NR_SB_ENTRIES % 65536) << 16) | ((CFG.NrCommitPorts % 256) << 8) | (CFG.NrIssuePorts % 256);
        f = '{CFG.RVA, CFG.RVB, CFG.RVC, CFG.RVD, CFG.RVF, CFG.RVH, CFG.RVS, CFG.RVU, CFG.RVV,
              CFG.RVZCB, CFG.RVZCMP, CFG.RVZiCond, CFG.RVZicntr, CFG.RVZihpm, CFG.XF16,
              CFG.XF16ALT, CFG.XF8, CFG.XFVec, CFG.CvxifEn, CFG.FpPresent, CFG.DebugEn,
              CFG.MmuPresent, CFG.SuperscalarEn};
        for (int i = 0; i < 23; i++) if (f[i]) tbl[2] += (32'd1 << i);
        tbl[3] = ((CFG.ICACHE_LINE_WIDTH % 65536) << 16) | ((CFG.ICACHE_SET_ASSOC % 256) << 8) | (CFG.ICACHE_INDEX_WIDTH % 256);
        tbl[4] = ((CFG.DCACHE_LINE_WIDTH % 65536) << 16) | ((CFG.DCACHE_SET_ASSOC % 256) << 8) | (CFG.DCACHE_INDEX_WIDTH % 256);
        tbl[5] = ((CFG.AxiDataWidth % 65536) << 16) | ((CFG.AxiIdWidth % 256) << 8) | (CFG.AxiAddrWidth % 256);
        tbl[6] = ((CFG.NrPMPEntries % 256) << 24) | ((CFG.InstrTlbEntries % 256) << 16) |
                 ((CFG.DataTlbEntries % 256) << 8) | (CFG.FLen % 256);
        tbl[7] = 32'(CFG.DmBaseAddress & 64'hFFFF_FFFF);
        s = 0;
        for (int i = 0; i < 8; i++) s += tbl[i];
        if (N == 9) tbl[8] = 0 - s;
    endtask

    // Stream model: mode 0 idle, 1 streaming word m_idx, 2 completion pulse.
    int m_mode = 0;
    int m_idx = 0;
    logic m_rv = 1'b0;
    logic [3:0] m_ra = '0;
    bit chk_en = 0;
    logic [31:0] dut_q[$];

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_idx = 0; m_rv = 1'b0;
        end else begin
            case (m_mode)
                0: if (start && !abort) begin m_mode = 1; m_idx = 0; end
                1: if (abort) m_mode = 0;
                   else if (out_ready) begin
                       if (m_idx == N - 1) m_mode = 2;
                       else m_idx++;
                   end
                default: m_mode = 0;
            endcase
            m_rv = rd_req;
            m_ra = rd_addr;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("valid", out_valid, m_mode == 1);
            if (m_mode == 1) begin
                check("idx", out_idx, m_idx);
                check("data", out_data, tbl[m_idx]);
                check("last", out_last, m_idx == N - 1);
            end
            check("done", done, m_mode == 2);
            check("busy", busy, m_mode != 0);
            check("rd_vld", rd_rsp_valid, m_rv);
            if (m_rv) begin
                check("rd_data", rd_data, (m_ra < N) ? tbl[m_ra] : 32'd0);
                check("rd_err", rd_err, m_ra >= N);
            end
            if (out_valid && out_ready && !abort && !rst) dut_q.push_back(out_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rmode: 0 ready high, 1 ready toggling, 2 ready high with a stray start, 3 random ready
    task automatic run_stream(input int rmode, output int hs, output int cyc);
        bit seen_done;
        hs = 0;
        seen_done = 0;
        dut_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("first_valid", out_valid, 1'b1);
        check("first_idx", out_idx, 4'd0);
        check("first_word", out_data, 32'h0038_0040);
        for (cyc = 1; cyc <= 200; cyc++) begin
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = cyc[0];
                2:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            start = (rmode == 2 && cyc == 3);
            if (out_valid && out_ready) hs++;
            tick();
            if (done) begin seen_done = 1; break; end
        end
        start = 1'b0;
        out_ready = 1'b0;
        check("stream_finished", seen_done, 1'b1);
        check("handshakes", hs, N);
        tick();
        check("done_one_cycle", done, 1'b0);
        check("idle_after", busy, 1'b0);
        check("captured_words", dut_q.size(), N);
    endtask

    int hs, cyc;
    logic [31:0] sum;
    logic [31:0] w8;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0; rd_req = 1'b0; rd_addr = '0;
        w8 = '0;
        build_model();
        check("model_w0", tbl[0], 32'h0038_0040);
        check("model_w1", tbl[1], 32'h0008_0201);
        check("model_w7", tbl[7], 32'h0000_0800);
        tick();
        chk_en = 1;
        tick();
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 32'd0);
        check("rst_idx", out_idx, 4'd0);
        check("rst_last", out_last, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rd", {rd_rsp_valid, rd_err}, 2'b00);
        check("rst_rd_data", rd_data, 32'd0);
        rst = 1'b0;
        tick();

        // full stream, ready held high: one word per cycle
        run_stream(0, hs, cyc);
        check("stream_cycles", cyc, N);
        sum = '0;
        foreach (dut_q[i]) sum += dut_q[i];
`ifdef CFG_INFO_CHECKSUM_EN
        check("checksum_zero", sum, 32'd0);
        if (dut_q.size() == 9) w8 = dut_q[8];
`else
        check("plain_sum", sum, tbl[0] + tbl[1] + tbl[2] + tbl[3] + tbl[4] + tbl[5] + tbl[6] + tbl[7]);
`endif

        run_stream(1, hs, cyc);
        check("toggle_cycles", cyc, 2 * N - 1);

        // abort on idx3 with a same-cycle handshake
        start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid && out_idx == 4'd3) break;
            tick();
        end
        check("reached_idx3", out_idx, 4'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0; out_ready = 1'b0;
        check("abort_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        tick();
        check("abort_no_done", done, 1'b0);

        run_stream(0, hs, cyc);

        // abort with start in idle stays idle
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_start_idle", busy, 1'b0);

        // back-to-back reads: ISA word then out-of-range
        rd_req = 1'b1; rd_addr = 4'd2;
        tick();
        rd_addr = 4'd9;
        check("rd2_valid", rd_rsp_valid, 1'b1);
        check("rd2_data", rd_data, tbl[2]);
        check("rd2_err", rd_err, 1'b0);
        tick();
        rd_req = 1'b0;
        check("rd9_valid", rd_rsp_valid, 1'b1);
        check("rd9_data", rd_data, 32'd0);
        check("rd9_err", rd_err, 1'b1);
        tick();
        check("rd_single_cycle", rd_rsp_valid, 1'b0);
`ifdef CFG_INFO_CHECKSUM_EN
        rd_req = 1'b1; rd_addr = 4'd8;
        tick();
        rd_req = 1'b0;
        check("rd8_matches_stream", rd_data, w8);
        check("rd8_err", rd_err, 1'b0);
`else
        rd_req = 1'b1; rd_addr = 4'd8;
        tick();
        rd_req = 1'b0;
        check("rd8_err", rd_err, 1'b1);
`endif

        run_stream(2, hs, cyc);
        run_stream(3, hs, cyc);

        // reset in the middle of a stream
        start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        rst = 1'b0; out_ready = 1'b0;
        tick();
        check("midrst_no_done", done, 1'b0);

        // random soak with concurrent reads, aborts and occasional reset
        for (int i = 0; i < 2000; i++) begin
            start     = ($urandom_range(0, 7) == 0);
            abort     = ($urandom_range(0, 15) == 0);
            out_ready = 1'($urandom_range(0, 1));
            rd_req    = 1'($urandom_range(0, 1));
            rd_addr   = 4'($urandom_range(0, 15));
            rst       = ($urandom_range(0, 199) == 0);
            tick();
        end
        start = 1'b0; abort = 1'b0; out_ready = 1'b0; rd_req = 1'b0; rst = 1'b0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
